// File: rtl/writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit_pkg
// Purpose  : Shared types for the multi-lane writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
package writeback_unit_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LOAD = 2'd2
    } wb_kind_t;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2
    } ld_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        COMMIT = 2'd2
    } wb_state_t;

    // Per-lane held control; destination and value are sized by the
    // instantiating module and stored alongside this entry.
    typedef struct packed {
        wb_kind_t kind;
        ld_size_t size;
        logic     sign;
        logic [1:0] off;
    } wb_ctrl_t;

    function automatic logic kind_writes(input wb_kind_t k);
        return (k == WB_ALU) || (k == WB_LOAD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit_if
// Purpose  : Bundle, data-response and register-file write bus of the
//            writeback stage.
// Revision : 1.0 - initial release
// ============================================================================
interface writeback_unit_if #(
    parameter int LANES          = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                             in_valid;
    logic                             in_ready;
    logic [LANES*2-1:0]               in_kind;
    logic [LANES*REG_ADDR_WIDTH-1:0]  in_dst;
    logic [LANES*DATA_WIDTH-1:0]      in_val;
    logic [LANES*2-1:0]               in_ldsize;
    logic [LANES-1:0]                 in_ldsign;
    logic [LANES*2-1:0]               in_ldoff;
    logic [LANES-1:0]                 dresp_valid;
    logic [LANES*DATA_WIDTH-1:0]      dresp_data;
    logic [LANES-1:0]                 wr_en;
    logic [LANES*REG_ADDR_WIDTH-1:0]  wr_reg;
    logic [LANES*DATA_WIDTH-1:0]      wr_word;
    logic                             busy;

    modport master (
        output in_valid, in_kind, in_dst, in_val, in_ldsize, in_ldsign,
               in_ldoff, dresp_valid, dresp_data,
        input  in_ready, wr_en, wr_reg, wr_word, busy
    );

    modport slave (
        input  in_valid, in_kind, in_dst, in_val, in_ldsize, in_ldsign,
               in_ldoff, dresp_valid, dresp_data,
        output in_ready, wr_en, wr_reg, wr_word, busy
    );
endinterface
`default_nettype wire

// File: rtl/writeback_unit_load_align.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit_load_align
// Purpose  : Aligns and extends raw load data. Byte/half handling is built
//            only with WB_SUBWORD_LOAD_EN; otherwise data passes through.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_unit_load_align
    import writeback_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  ld_size_t              i_size,
    input  logic                  i_sign,
    input  logic [1:0]            i_off,
    output logic [DATA_WIDTH-1:0] o_data
);

`ifdef WB_SUBWORD_LOAD_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_data[{i_off, 3'b000} +: 8];
        w_half = i_data[{i_off[1], 4'b0000} +: 16];
        case (i_size)
            LD_B:    o_data = {{(DATA_WIDTH-8){i_sign & w_byte[7]}}, w_byte};
            LD_H:    o_data = {{(DATA_WIDTH-16){i_sign & w_half[15]}}, w_half};
            default: o_data = i_data;
        endcase
    end
`else
    logic w_unused;
    assign w_unused = ^{i_size, i_sign, i_off};
    assign o_data   = i_data;
`endif

endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : writeback_unit
// Purpose  : Multi-lane writeback stage: holds a bundle until all load lanes
//            have data, then commits every lane in one cycle (youngest wins).
//            Optional macro: WB_SUBWORD_LOAD_EN (byte/half load alignment).
// Revision : 1.0 - initial release
// ============================================================================
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int LANES          = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    writeback_unit_if.slave  bus
);

    wb_state_t                 r_state;
    wb_state_t                 w_state_next;
    wb_ctrl_t                  r_ctrl [LANES];
    logic [REG_ADDR_WIDTH-1:0] r_dst  [LANES];
    logic [DATA_WIDTH-1:0]     r_val  [LANES];
    logic                      r_wait [LANES];
    logic [DATA_WIDTH-1:0]     w_aligned [LANES];
    logic [LANES-1:0]          w_in_load;
    logic [LANES-1:0]          w_capture;
    logic [LANES-1:0]          w_win;
    logic                      w_accept;
    logic                      w_wait_left;

    assign bus.in_ready = (r_state == IDLE) || (r_state == COMMIT);
    assign bus.busy     = (r_state == HOLD);
    assign w_accept     = bus.in_valid && bus.in_ready;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_in_load[i] = (bus.in_kind[2*i +: 2] == WB_LOAD);
            // Only HOLD can capture, so an accept-cycle response never counts.
            assign w_capture[i] = (r_state == HOLD) && r_wait[i] && bus.dresp_valid[i];

            writeback_unit_load_align #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_align (
                .i_data (bus.dresp_data[DATA_WIDTH*i +: DATA_WIDTH]),
                .i_size (r_ctrl[i].size),
                .i_sign (r_ctrl[i].sign),
                .i_off  (r_ctrl[i].off),
                .o_data (w_aligned[i])
            );

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_wait[i] <= 1'b0;
                    r_ctrl[i] <= '0;
                    r_dst[i]  <= '0;
                    r_val[i]  <= '0;
                end else if (w_accept) begin
                    r_wait[i]      <= w_in_load[i];
                    r_ctrl[i].kind <= wb_kind_t'(bus.in_kind[2*i +: 2]);
                    r_ctrl[i].size <= ld_size_t'(bus.in_ldsize[2*i +: 2]);
                    r_ctrl[i].sign <= bus.in_ldsign[i];
                    r_ctrl[i].off  <= bus.in_ldoff[2*i +: 2];
                    r_dst[i]       <= bus.in_dst[REG_ADDR_WIDTH*i +: REG_ADDR_WIDTH];
                    r_val[i]       <= bus.in_val[DATA_WIDTH*i +: DATA_WIDTH];
                end else if (w_capture[i]) begin
                    r_wait[i] <= 1'b0;
                    r_val[i]  <= w_aligned[i];
                end
            end
        end
    endgenerate

    always_comb begin
        w_wait_left = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (r_wait[i] && !w_capture[i]) begin
                w_wait_left = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, COMMIT: begin
                if (w_accept) begin
                    w_state_next = (|w_in_load) ? HOLD : COMMIT;
                end else begin
                    w_state_next = IDLE;
                end
            end
            HOLD: begin
                if (!w_wait_left) begin
                    w_state_next = COMMIT;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A lane loses to any younger lane in the bundle writing the same register.
    always_comb begin
        w_win = '0;
        for (int i = 0; i < LANES; i++) begin
            w_win[i] = kind_writes(r_ctrl[i].kind) && (r_dst[i] != '0);
            for (int j = i + 1; j < LANES; j++) begin
                if (kind_writes(r_ctrl[j].kind) && (r_dst[j] == r_dst[i])) begin
                    w_win[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.wr_en   = '0;
        bus.wr_reg  = '0;
        bus.wr_word = '0;
        if (r_state == COMMIT) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_win[i]) begin
                    bus.wr_en[i]                                    = 1'b1;
                    bus.wr_reg[REG_ADDR_WIDTH*i +: REG_ADDR_WIDTH]  = r_dst[i];
                    bus.wr_word[DATA_WIDTH*i +: DATA_WIDTH]         = r_val[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
# writeback_unit

Parametrised multi-lane writeback stage for the MIPS core. It accepts a bundle of up to LANES retiring instructions from the memory stage and holds it until every load lane has its data-bus response. It aligns and extends sub-word load data, then commits all lanes to the register file in one cycle with in-bundle ordering resolved. It replaces the single-lane writeback stage and adds dual-issue support, variable load latency and byte/half loads.

## Interface
Parameters:
- LANES, 2, instructions per bundle (1..4); lane 0 oldest
- DATA_WIDTH, 32, register/data width (multiple of 16)
- REG_ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  bundle offered
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_kind  in  LANES*2  per lane: 0 none, 1 ALU result, 2 load
- in_dst  in  LANES*REG_ADDR_WIDTH  destination register
- in_val  in  LANES*DATA_WIDTH  ALU result (ignored for loads)
- in_ldsize  in  LANES*2  0 byte, 1 half, 2 word
- in_ldsign  in  LANES  1 = sign-extend sub-word load
- in_ldoff  in  LANES*2  byte offset, i.e. address[1:0]
- dresp_valid  in  LANES  load data returned for lane
- dresp_data  in  LANES*DATA_WIDTH  raw bus word
- wr_en  out  LANES  register-file write strobe
- wr_reg  out  LANES*REG_ADDR_WIDTH  write index
- wr_word  out  LANES*DATA_WIDTH  write data
- busy  out  1  bundle held, waiting on load data

## Operation
- Bundle FSM states:
  - IDLE: no bundle held.
  - HOLD: bundle held, at least one load lane not yet captured.
  - COMMIT: all lanes ready; writes issue this cycle.
- Transitions:
  - On accept: IDLE or COMMIT goes to HOLD if any lane is a load, otherwise to COMMIT.
  - HOLD goes to COMMIT in the cycle after the last outstanding dresp_valid.
  - COMMIT goes to IDLE if no new bundle is accepted.
- in_ready = state is IDLE or COMMIT, giving back-to-back bundles with no bubble. busy = state is HOLD.
- Per-lane flag: WAIT is set on accept for load lanes. dresp_valid[i] with WAIT[i] set captures the aligned data and clears WAIT[i].
- dresp_valid is ignored in these cases:
  - lane i is not waiting;
  - the acceptance cycle itself (responses count from the following cycle).
- Alignment: byte takes data[8*off+:8]; half takes data[16*off[1]+:16], with off[0] ignored; word passes data through. The result is zero- or sign-extended to DATA_WIDTH per in_ldsign.
- COMMIT outputs:
  - wr_en[i] = 1 when kind[i] is ALU or load, dst[i] != 0, and no higher lane j>i in the bundle also writes dst[i] (youngest wins).
  - wr_reg and wr_word carry the held dst and value; both are 0 when wr_en[i] = 0.
- No lane ever writes outside a COMMIT cycle.
- A lane with kind none never waits.
- An all-none bundle reaches COMMIT with no writes.

## Timing
- Reset values: state IDLE, WAIT all 0, held bundle discarded. wr_en, wr_reg, wr_word, busy are 0. in_ready is 1 from the first cycle after reset.
- Reset asserted in HOLD drops the bundle; a late dresp_valid after reset is ignored.
- ALU-only bundle accepted at cycle t: writes at t+1.
- Load bundle accepted at t with its last response at t+k (k>=1): writes at t+k+1.
- Different lanes' responses may arrive in any order or cycle; the commit waits for the latest one.
- The data to be committed is captured no earlier than the response cycle.
- Writes are expected to be visible to reads in the cycle after wr_en.

## Configuration
- WB_SUBWORD_LOAD_EN defined: byte/half alignment and extension are implemented as above.
- WB_SUBWORD_LOAD_EN undefined: every load is treated as a word load. in_ldsize, in_ldsign and in_ldoff are ignored (tie-off as unused), and captured data equals dresp_data.

## Structure
- Shared package (defs.svh) holds:
  - wb_kind_t enum (WB_NONE, WB_ALU, WB_LOAD);
  - ld_size_t enum (LD_B, LD_H, LD_W);
  - wb_state_t enum (IDLE, HOLD, COMMIT);
  - a per-lane held-entry struct (kind, dst, val, size, sign, off).
- One combinational sub-module, load_align: raw word, size, sign, offset in; extended word out. It is instantiated once per lane under generate.

## Test plan
- Reset then an ALU bundle: lane0 r3=0x11, lane1 r4=0x22, accepted at t -> wr_en=2'b11 at t+1 with r3=0x11 and r4=0x22; busy never 1.
- Load lb, sign, off=1, raw 0x0000_8000 on lane0; dresp at t+3 -> busy t+1..t+3, wr_word=0xFFFF_FF80 at t+4. With the macro undefined -> 0x0000_8000.
- Same-register conflict: lane0 load to r5, lane1 ALU r5=0x7 -> the single commit has wr_en=2'b10 and r5=0x7.
- Out-of-order responses: lane1 dresp at t+1, lane0 at t+4 -> both lanes write together at t+5, nothing earlier.
- dst=0 ALU lane plus a spurious dresp_valid on an ALU lane -> no write to r0, and the commit cycle is unchanged.
- Reset asserted during HOLD, then dresp_valid the next cycle -> no writes, in_ready=1, state IDLE.
